// File: rtl/trap_shaper.sv
// rtl/trap_shaper.sv - trapezoidal pulse shaper (deconvolution, pole-zero correction, double accumulation)
//
// Purpose:
//    Shapes a stream of signed ADC samples into trapezoids. The path is
//    d = x - x[n-K] - x[n-L] + x[n-K-L], p += d, r = p + (d <<< M_SHIFT),
//    s += r. It runs as a three-stage pipeline: S1 takes the taps and d,
//    S2 takes p and r, S3 takes s and the output.
//    K and L are loaded at runtime. A rejected load sets a sticky error.
//    After reset or an accepted load, a counter clears the delay RAM.
//    Input samples are dropped while that clear is in progress.
//
// Optional feature macro: TRAP_SAT_EN
//    Clamps s to the OW range and drives out_sat. When the macro is
//    undefined, out_data is s wrapped to OW bits and out_sat is tied to 0.
//
// Ports:
//    clk, reset            single clock, synchronous active-high reset
//    in_valid, in_data     input sample stream (signed DW), no backpressure
//    cfg_load, cfg_k/l     one-cycle load of delays K and L (AW bits each)
//    cfg_err               sticky: the last cfg_load was rejected
//    out_valid, out_data   shaped result stream (signed OW), held between pulses
//    out_sat               out_data of this pulse was clamped (TRAP_SAT_EN only)

module trap_shaper #(
   parameter int DW      = 16,
   parameter int OW      = 32,
   parameter int DEPTH   = 64,
   parameter int M_SHIFT = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   input  logic                 cfg_load,
   input  logic [AW-1:0]        cfg_k,
   input  logic [AW-1:0]        cfg_l,
   output logic                 cfg_err,
   output logic                 out_valid,
   output logic signed [OW-1:0] out_data,
   output logic                 out_sat
);

   localparam int ACCW   = OW + 8;
   localparam int DDW    = DW + 2;
   localparam int KL_MAX = DEPTH - 1;

   typedef enum logic [0:0] {ST_FLUSH, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic [AW-1:0]           wp_q, wp_d;
   logic [AW-1:0]           k_q, k_d;
   logic [AW-1:0]           l_q, l_d;
   logic                    err_q, err_d;
   logic                    v1_q, v1_d;
   logic signed [DDW-1:0]   d1_q, d1_d;
   logic                    v2_q, v2_d;
   logic signed [ACCW-1:0]  p_q, p_d;
   logic signed [ACCW-1:0]  r_q, r_d;
   logic signed [ACCW-1:0]  s_q, s_d;
   logic                    ov_q, ov_d;
   logic signed [OW-1:0]    od_q, od_d;

   logic signed [DW-1:0]    ram_q [DEPTH];
   logic                    ram_we;
   logic [AW-1:0]           ram_addr;
   logic signed [DW-1:0]    ram_wdata;

   logic [AW:0]             kl_sum;
   logic                    cfg_ok;
   logic                    load_ok;
   logic                    accept;
   logic signed [DW-1:0]    tap_k, tap_l, tap_kl;
   logic signed [DDW-1:0]   d_now;
   logic signed [ACCW-1:0]  d1_ext;

`ifdef TRAP_SAT_EN
   localparam logic signed [ACCW-1:0] S_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] S_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
   logic os_q, os_d;
`endif

   // Taps are read asynchronously. The slot being written (wp) is never a
   // tap because K >= 1 and K+L <= DEPTH-1.
   assign tap_k  = ram_q[wp_q - k_q];
   assign tap_l  = ram_q[wp_q - l_q];
   assign tap_kl = ram_q[wp_q - k_q - l_q];

   always_comb begin
      kl_sum  = {1'b0, cfg_k} + {1'b0, cfg_l};
      cfg_ok  = (cfg_k != '0) && (cfg_k <= cfg_l) && (int'(kl_sum) <= KL_MAX);
      load_ok = cfg_load && cfg_ok;
      accept  = in_valid && (state_q == ST_RUN) && !load_ok;
      d_now   = DDW'(in_data) - DDW'(tap_k) - DDW'(tap_l) + DDW'(tap_kl);
      d1_ext  = ACCW'(d1_q);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wp_d      = wp_q;
      k_d       = k_q;
      l_d       = l_q;
      err_d     = err_q;
      v1_d      = 1'b0;
      d1_d      = d1_q;
      v2_d      = 1'b0;
      p_d       = p_q;
      r_d       = r_q;
      s_d       = s_q;
      ov_d      = 1'b0;
      od_d      = od_q;
`ifdef TRAP_SAT_EN
      os_d      = 1'b0;
`endif
      ram_we    = 1'b0;
      ram_addr  = wp_q;
      ram_wdata = in_data;

      // S1: write the sample, capture d
      if (accept) begin
         ram_we = 1'b1;
         wp_d   = wp_q + 1'b1;
         v1_d   = 1'b1;
         d1_d   = d_now;
      end

      // S2: first accumulator plus pole-zero term
      if (v1_q) begin
         v2_d = 1'b1;
         p_d  = p_q + d1_ext;
         r_d  = p_d + (d1_ext <<< M_SHIFT);
      end

      // S3: second accumulator and output reduction
      if (v2_q) begin
         ov_d = 1'b1;
         s_d  = s_q + r_q;
`ifdef TRAP_SAT_EN
         if (s_d > S_MAX) begin
            od_d = S_MAX[OW-1:0];
            os_d = 1'b1;
         end else if (s_d < S_MIN) begin
            od_d = S_MIN[OW-1:0];
            os_d = 1'b1;
         end else begin
            od_d = s_d[OW-1:0];
         end
`else
         od_d = s_d[OW-1:0];
`endif
      end

      // Clear one RAM entry per cycle. Taps read zero until real samples arrive.
      if (state_q == ST_FLUSH) begin
         ram_we    = 1'b1;
         ram_addr  = cnt_q;
         ram_wdata = '0;
         cnt_d     = cnt_q + 1'b1;
         wp_d      = '0;
         if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = ST_RUN;
         end
      end

      // An accepted load discards everything in flight. out_data keeps its last value.
      if (cfg_load) begin
         if (cfg_ok) begin
            k_d     = cfg_k;
            l_d     = cfg_l;
            err_d   = 1'b0;
            state_d = ST_FLUSH;
            cnt_d   = '0;
            wp_d    = '0;
            ram_we  = 1'b0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            ov_d    = 1'b0;
            od_d    = od_q;
            p_d     = '0;
            s_d     = '0;
`ifdef TRAP_SAT_EN
            os_d    = 1'b0;
`endif
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FLUSH;
         cnt_q   <= '0;
         wp_q    <= '0;
         k_q     <= AW'(2);
         l_q     <= AW'(4);
         err_q   <= 1'b0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
         v2_q    <= 1'b0;
         p_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
`ifdef TRAP_SAT_EN
         os_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wp_q    <= wp_d;
         k_q     <= k_d;
         l_q     <= l_d;
         err_q   <= err_d;
         v1_q    <= v1_d;
         d1_q    <= d1_d;
         v2_q    <= v2_d;
         p_q     <= p_d;
         r_q     <= r_d;
         s_q     <= s_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
`ifdef TRAP_SAT_EN
         os_q    <= os_d;
`endif
      end
   end

   // Delay RAM. It is cleared by the flush that always follows a reset,
   // and no sample is accepted until that flush completes.
   always_ff @(posedge clk) begin
      if (!reset && ram_we) begin
         ram_q[ram_addr] <= ram_wdata;
      end
   end

   assign cfg_err   = err_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;
`ifdef TRAP_SAT_EN
   assign out_sat   = os_q;
`else
   assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_trap_shaper.sv
// tb/tb_trap_shaper.sv - randomized self-checking bench for trap_shaper against a behavioural model

module tb_trap_shaper;

   localparam int DEPTH = 64;
   localparam int MULT  = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               cfg_load = 1'b0;
   logic [5:0]         cfg_k = '0;
   logic [5:0]         cfg_l = '0;

   logic               cfg_err_a, out_valid_a, out_sat_a;
   logic signed [31:0] out_data_a;
   logic               cfg_err_b, out_valid_b, out_sat_b;
   logic signed [15:0] out_data_b;

   always #5 clk = ~clk;

   trap_shaper #(.DW(16), .OW(32), .DEPTH(DEPTH), .M_SHIFT(4)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_err(cfg_err_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_sat(out_sat_a)
   );

   trap_shaper #(.DW(16), .OW(16), .DEPTH(DEPTH), .M_SHIFT(4)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_err(cfg_err_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_sat(out_sat_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: accepted samples since the last flush, exact p and s.
   int     mk = 2, ml = 4, flush_left = DEPTH;
   bit     merr = 1'b0;
   longint hist[$];
   longint mp = 0, ms = 0;
   bit     va = 1'b0, vb = 1'b0, m_ov = 1'b0;
   longint sa = 0, sb = 0, m_s = 0;

   longint cap_a[$];
   longint cap_b[$];
   longint cap_sb[$];
   longint e10[10];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint xs(input int idx);
      return (idx < 0) ? 64'sd0 : hist[idx];
   endfunction

   function automatic longint red(input longint s, input int ow);
`ifdef TRAP_SAT_EN
      longint mx = (longint'(1) <<< (ow - 1)) - 1;
      if (s > mx) return mx;
      if (s < -mx - 1) return -mx - 1;
      return s;
`else
      return (s <<< (64 - ow)) >>> (64 - ow);
`endif
   endfunction

   function automatic longint satf(input longint s, input int ow);
`ifdef TRAP_SAT_EN
      longint mx = (longint'(1) <<< (ow - 1)) - 1;
      return (s > mx || s < -mx - 1) ? 64'sd1 : 64'sd0;
`else
      return 64'sd0 + (s & 0);
`endif
   endfunction

   task automatic model_step();
      bit     load_ok, acc;
      int     k, l, n;
      longint d;
      if (reset) begin
         mk = 2; ml = 4; merr = 1'b0; flush_left = DEPTH;
         hist.delete(); mp = 0; ms = 0;
         va = 1'b0; vb = 1'b0; m_ov = 1'b0; m_s = 0;
         return;
      end
      k = int'(cfg_k);
      l = int'(cfg_l);
      load_ok = cfg_load && k >= 1 && k <= l && (k + l) <= DEPTH - 1;
      if (cfg_load && !load_ok) merr = 1'b1;
      if (load_ok) begin
         mk = k; ml = l; merr = 1'b0; flush_left = DEPTH;
         hist.delete(); mp = 0; ms = 0;
         va = 1'b0; vb = 1'b0; m_ov = 1'b0;
         return;
      end
      m_ov = vb;
      if (vb) m_s = sb;
      vb = va; sb = sa; va = 1'b0;
      if (flush_left > 0) begin
         flush_left--;
         acc = 1'b0;
      end else begin
         acc = in_valid;
      end
      if (acc) begin
         hist.push_back(longint'(in_data));
         n  = hist.size() - 1;
         d  = xs(n) - xs(n - mk) - xs(n - ml) + xs(n - mk - ml);
         mp = mp + d;
         ms = ms + mp + d * MULT;
         va = 1'b1;
         sa = ms;
      end
   endtask

   task automatic check_all();
      check("valid_a", out_valid_a, m_ov);
      check("data_a",  out_data_a,  red(m_s, 32));
      check("sat_a",   out_sat_a,   m_ov ? satf(m_s, 32) : 0);
      check("err_a",   cfg_err_a,   merr);
      check("valid_b", out_valid_b, m_ov);
      check("data_b",  out_data_b,  red(m_s, 16));
      check("sat_b",   out_sat_b,   m_ov ? satf(m_s, 16) : 0);
      check("err_b",   cfg_err_b,   merr);
      if (out_valid_a) cap_a.push_back(out_data_a);
      if (out_valid_b) begin
         cap_b.push_back(out_data_b);
         cap_sb.push_back(longint'(out_sat_b));
      end
   endtask

   task automatic cyc(input bit v, input longint x);
      in_valid = v;
      in_data  = 16'(x);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      cfg_load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0);
   endtask

   task automatic load(input int k, input int l, input bit v);
      cfg_load = 1'b1;
      cfg_k    = 6'(k);
      cfg_l    = 6'(l);
      cyc(v, 777);
   endtask

   task automatic impulse(input longint amp, input int n, input bit gaps);
      int idx = 0;
      bit v;
      cap_a.delete(); cap_b.delete(); cap_sb.delete();
      while (idx < n) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         cyc(v, (idx == 0) ? amp : 0);
         if (v) idx++;
      end
      idle(4);
   endtask

   task automatic cmp_list(input string tag, input int n_len);
      check({tag, "_len"}, cap_a.size(), n_len);
      for (int i = 0; i < 10 && i < cap_a.size(); i++) check(tag, cap_a[i], e10[i]);
   endtask

   task automatic rand_run(input int n, input int amp);
      for (int i = 0; i < n; i++)
         cyc(1'($urandom_range(0, 3) != 0), longint'($urandom_range(0, 2 * amp)) - amp);
   endtask

   initial begin
      reset = 1'b1;
      cyc(1'b0, 0);
      cyc(1'b1, 5);
      reset = 1'b0;
      idle(DEPTH + 2);

      // Impulse response, K=2 L=4
      e10 = '{17, 18, 2, 2, -15, -16, 0, 0, 0, 0};
      impulse(1, 12, 1'b0);
      cmp_list("impulse", 12);

      // Step of 1000
      e10 = '{17000, 35000, 37000, 39000, 24000, 8000, 8000, 8000, 8000, 8000};
      cap_a.delete();
      for (int i = 0; i < 20; i++) cyc(1'b1, 1000);
      idle(4);
      cmp_list("step", 20);

      // Flush, then impulse with random input gaps
      load(2, 4, 1'b1);
      idle(DEPTH + 2);
      e10 = '{17, 18, 2, 2, -15, -16, 0, 0, 0, 0};
      impulse(1, 12, 1'b1);
      cmp_list("gap_impulse", 12);

      // Full-scale impulse: clamp or wrap on the 16-bit instance
      impulse(32767, 8, 1'b0);
      check("big_len", cap_b.size(), 8);
      if (cap_b.size() > 0) begin
`ifdef TRAP_SAT_EN
         check("big_b", cap_b[0], 32767);
         check("big_sat", cap_sb[0], 1);
`else
         check("big_b", cap_b[0], 32751);
         check("big_sat", cap_sb[0], 0);
`endif
      end
      if (cap_a.size() > 0) check("big_a", cap_a[0], 557039);

      // Rejected load keeps K=2 L=4
      load(5, 3, 1'b0);
      check("rej_err", cfg_err_a, 1);
      impulse(1, 12, 1'b0);
      cmp_list("rej_impulse", 12);

      rand_run(150, 300);

      // Mid-stream load K=3 L=5: samples are dropped and nothing comes out during the flush
      cap_a.delete();
      load(3, 5, 1'b1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 777);
      idle(2);
      check("flush_quiet", cap_a.size(), 0);
      e10 = '{17, 18, 19, 3, 3, -14, -15, -16, 0, 0};
      impulse(1, 12, 1'b0);
      cmp_list("k3l5_impulse", 12);

      rand_run(100, 300);

      // Reset mid-stream, with the sticky error set beforehand
      load(0, 4, 1'b0);
      rand_run(5, 300);
      reset = 1'b1;
      cyc(1'b1, 123);
      check("rst_valid", out_valid_a, 0);
      check("rst_data", out_data_a, 0);
      check("rst_err", cfg_err_a, 0);
      reset = 1'b0;
      rand_run(DEPTH + 60, 300);

      // Load boundary cases
      load(32, 32, 1'b0);
      rand_run(20, 300);
      load(20, 43, 1'b0);
      rand_run(DEPTH + 120, 300);
      load(31, 31, 1'b0);
      rand_run(DEPTH + 80, 300);
      load(1, 1, 1'b0);
      rand_run(DEPTH + 60, 300);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_shaper.md
# trap_shaper

Parametrised trapezoidal pulse shaper: second generation of the team's fixed-coefficient deconvolution/shaping filter. It takes a stream of signed ADC samples and applies the two-delay deconvolution, pole-zero correction and double accumulation. It outputs a shaped stream with a valid strobe. Delays are runtime-loadable, all widths are parametrised, and the output has a sample-valid handshake. It sits between the ADC capture front-end and the peak/energy extractor.

## Interface
- `DW`, 16: input sample width, signed two's complement.
- `OW`, 32: output width, signed.
- `DEPTH`, 64: delay-line entries, power of two; `AW = clog2(DEPTH)`.
- `M_SHIFT`, 4: pole-zero multiplier, `M = 2^M_SHIFT`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: `in_data` is a new sample this cycle.
- `in_data` in `DW`: signed sample.
- `cfg_load` in 1: one-cycle pulse; latch `cfg_k`/`cfg_l` and flush.
- `cfg_k` in `AW`: delay K.
- `cfg_l` in `AW`: delay L.
- `cfg_err` out 1: sticky; last `cfg_load` was rejected.
- `out_valid` out 1: `out_data` holds a new result.
- `out_data` out `OW`: shaped sample, signed.
- `out_sat` out 1: the current `out_data` was clamped. Present only with `TRAP_SAT_EN`; otherwise tied 0.

## Operation
- Defaults after `reset`: K=2, L=4.
  - All outputs are 0.
  - The delay RAM, write pointer, d/p/s registers and pipeline valids are 0.
- Accepted sample x[n] is written to a circular delay RAM at the write pointer, which then increments modulo `DEPTH`.
  - Taps are read at `wp-K`, `wp-L` and `wp-K-L` (mod `DEPTH`).
  - Samples before the line fills read as 0 because the RAM is cleared.
- Arithmetic, per accepted sample, in internal signed width `ACCW = OW+8`:
  - d[n] = x[n] − x[n−K] − x[n−L] + x[n−K−L], width `DW+2`.
  - p[n] = p[n−1] + d[n].
  - r[n] = p[n] + (d[n] <<< `M_SHIFT`).
  - s[n] = s[n−1] + r[n].
- p and s wrap in two's complement. Results are exact whenever the true s fits in `ACCW`.
- Output: `out_data` = s[n] reduced to `OW` (see Configuration).
- Idle cycles (`in_valid`=0) do not advance the pointer or the accumulators.
- `cfg_load` validity: accepted iff 1 ≤ `cfg_k` ≤ `cfg_l` and `cfg_k` + `cfg_l` ≤ `DEPTH`−1.
  - Accepted: new K/L latched. RAM, p, s and pipeline valids are cleared over the flush. `cfg_err` is cleared.
  - Rejected: old K/L kept, no flush, `cfg_err`=1.
- RAM flush: a counter walks all `DEPTH` entries.
  - `in_valid` is ignored, and samples are dropped, for `DEPTH` cycles after an accepted `cfg_load`.
  - Flushing is also performed after `reset`.
  - `flushing` is internal. The state machine is IDLE/RUN → FLUSH → RUN.
- `reset` during flush or mid-stream aborts everything and restarts the flush. `reset` has priority over `cfg_load`.
- `cfg_load` and `in_valid` in the same cycle: the config takes effect and that sample is dropped.

## Timing
- Pipeline stages:
  - S1 captures the taps and d at edge N.
  - S2 captures p and r at edge N+1.
  - S3 captures s and the output at edge N+2.
- `out_valid` is high for exactly one cycle after edge N+2 for each sample accepted at edge N.
- Pipeline throughput is one sample per clock. There is no backpressure; the consumer must accept every `out_valid`.
- `out_data` holds its value between `out_valid` pulses.
- Back-to-back samples give back-to-back `out_valid` pulses. Gaps in the input are preserved at the output.
- Flush lasts `DEPTH` cycles after the edge that samples `reset`=0 after `reset`, or after an accepted `cfg_load`. The first sample is accepted on the following edge.

## Configuration
- `TRAP_SAT_EN` defined:
  - s is clamped to [−2^(OW−1), 2^(OW−1)−1].
  - `out_sat`=1 alongside a clamped `out_valid`, else 0.
- `TRAP_SAT_EN` undefined:
  - `out_data` = s[OW−1:0] (wrap).
  - `out_sat` is constant 0 and the clamp logic is absent.

## Test plan
- Impulse, with K=2, L=4, M_SHIFT=4 and input 1, 0, 0, …: `out_data` = 17, 18, 2, 2, −15, −16, 0, 0, …. First `out_valid` appears 3 edges after acceptance.
- Constant input of 1000 for 20 samples, same config: outputs 17000, 35000, 37000, 39000, 24000, then 8000 held from the 6th result on.
- Same impulse with random `in_valid` gaps: identical value sequence, and the `out_valid` pattern equals the input pattern delayed by 3 cycles.
- `OW`=16, impulse of 32767:
  - With `TRAP_SAT_EN`: first output 32767 with `out_sat`=1.
  - Without it: first output 32751.
- `cfg_load` with K=5, L=3: `cfg_err`=1 and the impulse response is unchanged.
- `cfg_load` with K=3, L=5 issued mid-stream, followed by an impulse: no `out_valid` for `DEPTH` cycles. The impulse response then shows d spikes at offsets 0, 3, 5 and 8, with no residue from earlier samples.
- `reset` asserted mid-stream: all outputs 0 on the next cycle, and the flush restarts.
